// File: rtl/mac_frame_accumulator.sv
// mac_frame_accumulator
// Sums N consecutive unsigned 2W-bit multiply-add results into one frame sum
// and offers it downstream. While a sum is waiting, the upstream stage is
// held off with in_ready.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both 1. A valid source holds its data stable until
// that edge. in_ready is combinational from state only (1 in ACC, 0 in OUT)
// and never depends on in_valid. out_valid/out_sum are registered and never
// depend on out_ready. clear has priority over both transfers.
module mac_frame_accumulator #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*W-1:0]              in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*W+$clog2(N)-1:0]    out_sum,
  output logic [15:0]                 out_frames,
  output logic                        state_dbg
);

  // Sum width: N*(2^(2W)-1) always fits, so the accumulator cannot wrap.
  localparam int SW = 2 * W + $clog2(N);
  // Sample counter counts 0..N-1; keep at least one bit for N=1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   out_sum_q, out_sum_d;
  logic [15:0]     out_frames_q, out_frames_d;

  logic            in_fire;
  logic [SW-1:0]   acc_plus;

  assign in_ready   = (state_q == ST_ACC);
  assign in_fire    = in_valid && in_ready;
  assign acc_plus   = acc_q + SW'(in_data);

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_frames = out_frames_q;
  assign state_dbg  = state_q;

  // Next-state: clear aborts the frame or drops a pending sum; otherwise
  // accumulate in ACC and wait for the downstream handshake in OUT.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_frames_d = out_frames_q;

    if (clear) begin
      // Any sample offered this cycle is discarded; a pending sum is not counted.
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_fire) begin
            if (cnt_q == CNT_LAST) begin
              // Nth sample: publish the sum and restart the accumulator.
              out_sum_d   = acc_plus;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = ST_OUT;
            end else begin
              acc_d = acc_plus;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_OUT: begin
          // out_sum is held; out_sum keeps its value after the handshake.
          if (out_ready) begin
            out_valid_d  = 1'b0;
            out_frames_d = out_frames_q + 16'd1;
            state_d      = ST_ACC;
          end
        end
        default: begin
          state_d     = ST_ACC;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ACC;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_frames_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_frames_q <= out_frames_d;
    end
  end

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Bench for mac_frame_accumulator: one N=4 instance driven through a
// scoreboard of expected frame sums, plus one N=1 instance with directed checks.
module tb_mac_frame_accumulator;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int SW  = 2 * W + $clog2(N);
  localparam int SW1 = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // N=4 instance signals
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*W-1:0]    in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SW-1:0]     out_sum;
  logic [15:0]       out_frames;
  logic              state_dbg;

  // N=1 instance signals
  logic              clear1 = 1'b0;
  logic              in1_valid = 1'b0;
  logic              in1_ready;
  logic [2*W-1:0]    in1_data = '0;
  logic              out1_valid;
  logic              out1_ready = 1'b0;
  logic [SW1-1:0]    out1_sum;
  logic [15:0]       out1_frames;
  logic              state1_dbg;

  mac_frame_accumulator #(.W(W), .N(N)) u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_frames(out_frames), .state_dbg(state_dbg)
  );

  mac_frame_accumulator #(.W(W), .N(1)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear1),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_sum(out1_sum),
    .out_frames(out1_frames), .state_dbg(state1_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [SW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [31:0]   m_acc = 0;
  int            m_cnt = 0;
  int            m_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pop and compare at the negedge before each delivering edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(out_sum), 32'hFFFF_FFFF);
      end else begin
        check("frame_sum", 32'(out_sum), 32'(exp_q.pop_front()));
        m_frames++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, waiting (bounded) for in_ready; update the model.
  task automatic send(input logic [2*W-1:0] d);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    m_acc += 32'(d);
    m_cnt++;
    if (m_cnt == N) begin
      exp_q.push_back(SW'(m_acc));
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_frames", 32'(out_frames), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Basic frame 1,2,3,4 with out_ready=1
    out_ready = 1'b1;
    send(1); send(2); send(3);
    check("in_ready_mid_frame", 32'(in_ready), 32'd1);
    send(4);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out_sum", 32'(out_sum), 32'd10);
    check("basic_in_ready_low", 32'(in_ready), 32'd0);
    check("basic_frames_before", 32'(out_frames), 32'd0);
    drain();
    check("basic_frames_after", 32'(out_frames), 32'd1);
    check("basic_out_valid_drop", 32'(out_valid), 32'd0);

    // Maximum values: no wrap, then accumulator restart
    for (int i = 0; i < 4; i++) send(16'd65025);
    send(0); send(0); send(0); send(1);
    drain();
    check("max_frames", 32'(out_frames), 32'(m_frames));

    // Back-pressure: sum held, input ignored
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    in_valid = 1'b1;
    in_data  = 16'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'd10);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_frames", 32'(out_frames), 32'(m_frames));
    send(7); send(7); send(7); send(7);
    drain();

    // Clear in ACC discards partial frame and the simultaneous sample
    send(9); send(9);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'd9;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    m_acc = 0; m_cnt = 0;
    send(5); send(5); send(5); send(5);
    drain();

    // Clear in OUT with out_ready the same cycle: frame dropped, not counted
    out_ready = 1'b0;
    send(1); send(1); send(1); send(1);
    check("clr_out_pending", 32'(out_valid), 32'd1);
    clear = 1'b1; out_ready = 1'b1;
    void'(exp_q.pop_back());
    tick();
    clear = 1'b0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_out_frames", 32'(out_frames), 32'(m_frames));
    check("clr_out_sum_held", 32'(out_sum), 32'd4);
    check("clr_in_ready", 32'(in_ready), 32'd1);

    // Gapped input
    for (int i = 0; i < 4; i++) begin
      send(16'(i + 1));
      for (int g = 0; g < i; g++) tick();
    end
    drain();
    check("gap_frames", 32'(out_frames), 32'(m_frames));

    // Reset mid-frame: asynchronous return to zero
    send(8); send(8);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_frames", 32'(out_frames), 32'd0);
    check("arst_out_sum", 32'(out_sum), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    m_acc = 0; m_cnt = 0; m_frames = 0;
    tick();
    send(1); send(1); send(1); send(1);
    drain();
    check("arst_frames_after", 32'(out_frames), 32'd1);

    // N=1 instance: each sample becomes a frame, one idle cycle after each
    out1_ready = 1'b1;
    in1_valid  = 1'b1;
    in1_data   = 16'd3;
    tick();
    check("n1_valid_a", 32'(out1_valid), 32'd1);
    check("n1_sum_a", 32'(out1_sum), 32'd3);
    check("n1_ready_low_a", 32'(in1_ready), 32'd0);
    in1_data = 16'd4;
    tick();
    check("n1_ready_back", 32'(in1_ready), 32'd1);
    check("n1_frames_a", 32'(out1_frames), 32'd1);
    tick();
    in1_valid = 1'b0;
    check("n1_valid_b", 32'(out1_valid), 32'd1);
    check("n1_sum_b", 32'(out1_sum), 32'd4);
    check("n1_ready_low_b", 32'(in1_ready), 32'd0);
    tick();
    check("n1_frames_b", 32'(out1_frames), 32'd2);

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_frame_accumulator.md
Name: mac_frame_accumulator

Overview:
Downstream consumer of the multiply-add stage that produces A*B+C every clock. It sums a fixed number N of consecutive 2W-bit results into one frame sum. It presents each frame sum on a valid/ready output handshake and back-pressures the upstream stage with in_ready while a sum is waiting.

Parameters:
W, 8, operand width of the upstream multiply-add stage; in_data is 2W bits.
N, 4, number of accepted samples per frame; legal range N >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous frame abort/flush.
in_valid  input  1  upstream sample valid.
in_ready  output  1  block can accept a sample this cycle.
in_data  input  2W  upstream multiply-add result, unsigned.
out_valid  output  1  frame sum valid.
out_ready  input  1  downstream accepts frame sum.
out_sum  output  2W+$clog2(N)  frame sum, unsigned.
out_frames  output  16  count of frames delivered; wraps at 65535.

Behaviour:
- Reset: clk, reset asynchronous active-high. Reset forces state ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_frames=0. in_ready is 1 immediately after reset deasserts.
- Widths: acc and out_sum are 2W+$clog2(N) bits. Overflow is impossible because N*(2^(2W)-1) < 2^(2W+clog2 N). For N=1 the width is 2W.
- cnt is max(1,$clog2(N)) bits and counts 0..N-1.
- Sample accept: in_valid && in_ready on a rising clk edge. With in_valid=0 nothing changes, so gaps are allowed.
- in_ready is combinational: 1 in ACC, 0 in OUT.
- State ACC, accept with cnt < N-1: acc <= acc+in_data, cnt <= cnt+1.
- State ACC, accept with cnt == N-1: out_sum <= acc+in_data, out_valid <= 1, acc <= 0, cnt <= 0, go to OUT.
- Latency: out_valid rises on the edge that accepts the Nth sample and is visible 1 cycle after that sample's in_valid cycle.
- State OUT: out_sum and out_valid are held stable. in_ready=0, so in_data is ignored even if in_valid=1.
- State OUT, out_valid && out_ready on an edge: out_valid <= 0, out_frames <= out_frames+1, go to ACC. The next sample can be accepted on the following cycle, never on the handshake cycle.
- out_ready asserted while out_valid=0 has no effect.
- clear in ACC: acc <= 0, cnt <= 0. Any sample presented that cycle is discarded, even though in_ready=1 (clear has priority over accept).
- clear in OUT: the pending sum is dropped. out_valid <= 0, out_frames unchanged, go to ACC. clear has priority over a simultaneous out_ready; the frame is not counted.
- out_sum keeps its last value after handshake or clear; only out_valid qualifies it.
- N=1: every accepted sample goes straight to OUT with out_sum = in_data. Throughput is one sample per 2 cycles at best.
- Reset mid-frame or mid-OUT: everything returns to reset values at once, with no output handshake completed.
- Sustained throughput: N samples per N+1 cycles when out_ready is held at 1.

Test Plan:
- W=8, N=4, in_valid=1 for 4 cycles with in_data 1,2,3,4, out_ready=1: out_valid=1 one cycle after the 4th sample with out_sum=10. in_ready=0 that cycle. out_frames goes 0->1.
- W=8, N=4, four samples of 65025: out_sum=260100 (18 bits, no wrap). A following frame of 0,0,0,1 gives out_sum=1, proving acc restarted at 0.
- Back-pressure: after a frame with sum 10, hold out_ready=0 for 5 cycles while in_valid=1 with in_data=7. Required: out_sum stays 10, in_ready=0 throughout, and no 7 is accumulated. Release out_ready, then feed 7,7,7,7: next out_sum=28.
- Clear: feed 9,9, then clear=1 with in_valid=1 and in_data=9, then feed 5,5,5,5: out_sum=20. Separately, clear in OUT with out_ready=1 the same cycle: out_valid drops and out_frames is unchanged.
- Gapped input: samples 1,2,3,4 with in_valid=0 gaps of 0..3 cycles between them: out_sum=10. Also N=1 with inputs 3 then 4: two sums, 3 and 4, with in_ready low for one cycle after each.
- Reset mid-frame: after samples 8,8 assert reset for 1 cycle. All outputs go to 0 asynchronously. Then 1,1,1,1 gives out_sum=4 and out_frames=1.
